// File: rtl/parking_pkg.sv
// Shared definitions for the parking carrier motion blocks: sequencer states,
// grid limits, default motion timing and a small cell-distance helper.
package parking_pkg;

    localparam int unsigned GRID_MAX             = 3;
    localparam int unsigned STEPS_PER_CELL_DEF   = 1600;
    localparam int unsigned STEP_HALF_PERIOD_DEF = 25000;
    localparam int unsigned SETTLE_CYCLES_DEF    = 500000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE_X,
        S_SETTLE_X,
        S_MOVE_Y,
        S_SETTLE_Y,
        S_DONE
    } seq_state_e;

    // Unsigned distance in cells between two grid coordinates.
    function automatic logic [2:0] cell_dist(input logic [1:0] a, input logic [1:0] b);
        if (a >= b) return {1'b0, a} - {1'b0, b};
        else        return {1'b0, b} - {1'b0, a};
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Step pulse train for one stepper axis: square wave starting low, with a
// one-cycle cell_done strobe on the edge that produces the cell's last fall.
module step_pulse_gen #(
    parameter int unsigned STEPS_PER_CELL = 1600,
    parameter int unsigned HALF_PERIOD    = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic step_o,
    output logic cell_done_o,
    output logic mid_cell_o
);

    localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [PW-1:0] phase_q;
    logic [15:0]   steps_q;
    logic          step_q;
    logic          half_done;
    logic          fall;

    assign half_done   = run_i && (phase_q == PW'(HALF_PERIOD - 1));
    assign fall        = half_done && step_q;
    assign cell_done_o = fall && (steps_q == 16'(STEPS_PER_CELL - 1));
    assign mid_cell_o  = (steps_q != 16'd0);
    assign step_o      = step_q;

    // Dropping run_i returns everything to the idle-low state on the next edge.
    always_ff @(posedge clk) begin
        if (rst || !run_i) begin
            phase_q <= '0;
            steps_q <= '0;
            step_q  <= 1'b0;
        end else begin
            if (half_done) begin
                phase_q <= '0;
                step_q  <= ~step_q;
            end else begin
                phase_q <= phase_q + PW'(1);
            end
            if (fall) steps_q <= cell_done_o ? 16'd0 : steps_q + 16'd1;
        end
    end

endmodule

// File: rtl/parking_coord_sequencer.sv
// Grid-coordinate move sequencer: turns a target cell command into an X move,
// a settle dwell, a Y move and a final dwell, tracking completed cell position.
module parking_coord_sequencer
    import parking_pkg::*;
#(
    parameter int unsigned STEPS_PER_CELL   = STEPS_PER_CELL_DEF,
    parameter int unsigned STEP_HALF_PERIOD = STEP_HALF_PERIOD_DEF,
    parameter int unsigned SETTLE_CYCLES    = SETTLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coord_cmd_valid,
    input  logic [1:0] target_x,
    input  logic [1:0] target_y,
    input  logic       abort,
    output logic       x_step,
    output logic       x_dir,
    output logic       x_en,
    output logic       y_step,
    output logic       y_dir,
    output logic       y_en,
    output logic [1:0] cur_x,
    output logic [1:0] cur_y,
    output logic       busy,
    output logic       arrived,
    output logic       cmd_dropped,
    output logic       pos_lost
);

    localparam int unsigned SW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [1:0]  CELL_MAX = 2'(GRID_MAX);

    seq_state_e    state_q;
    logic [1:0]    tx_q, ty_q;
    logic [1:0]    cur_x_q, cur_y_q;
    logic [2:0]    cells_x_q, cells_y_q;
    logic [2:0]    dist_x, dist_y;
    logic [SW-1:0] settle_q;
    logic          settle_end;
    logic          x_dir_q, y_dir_q, x_en_q, y_en_q;
    logic          busy_q, arrived_q, cmd_dropped_q, pos_lost_q;
    logic          run_x, run_y;
    logic          x_cell_done, y_cell_done, x_mid, y_mid;
    logic          abort_hit;

    assign abort_hit  = abort && (state_q != S_IDLE);
    assign run_x      = (state_q == S_MOVE_X) && !abort;
    assign run_y      = (state_q == S_MOVE_Y) && !abort;
    assign dist_x     = cell_dist(tx_q, cur_x_q);
    assign dist_y     = cell_dist(ty_q, cur_y_q);
    assign settle_end = (settle_q == SW'(SETTLE_CYCLES - 1));

    step_pulse_gen #(.STEPS_PER_CELL(STEPS_PER_CELL), .HALF_PERIOD(STEP_HALF_PERIOD)) u_x_gen (
        .clk(clk), .rst(rst), .run_i(run_x),
        .step_o(x_step), .cell_done_o(x_cell_done), .mid_cell_o(x_mid)
    );

    step_pulse_gen #(.STEPS_PER_CELL(STEPS_PER_CELL), .HALF_PERIOD(STEP_HALF_PERIOD)) u_y_gen (
        .clk(clk), .rst(rst), .run_i(run_y),
        .step_o(y_step), .cell_done_o(y_cell_done), .mid_cell_o(y_mid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tx_q          <= '0;
            ty_q          <= '0;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            cells_x_q     <= '0;
            cells_y_q     <= '0;
            settle_q      <= '0;
            x_dir_q       <= 1'b0;
            y_dir_q       <= 1'b0;
            x_en_q        <= 1'b0;
            y_en_q        <= 1'b0;
            busy_q        <= 1'b0;
            arrived_q     <= 1'b0;
            cmd_dropped_q <= 1'b0;
            pos_lost_q    <= 1'b0;
        end else begin
            arrived_q     <= 1'b0;
            cmd_dropped_q <= coord_cmd_valid && (state_q != S_IDLE);
            if (abort_hit) begin
                // Completed cells stay counted; only a partly stepped cell loses position.
                state_q  <= S_IDLE;
                settle_q <= '0;
                x_en_q   <= 1'b0;
                y_en_q   <= 1'b0;
                busy_q   <= 1'b0;
                if (x_mid || y_mid) pos_lost_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (coord_cmd_valid) begin
                            tx_q    <= target_x;
                            ty_q    <= target_y;
                            busy_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        x_dir_q   <= (tx_q > cur_x_q);
                        y_dir_q   <= (ty_q > cur_y_q);
                        cells_x_q <= dist_x;
                        cells_y_q <= dist_y;
                        if (dist_x != 3'd0) begin
                            x_en_q  <= 1'b1;
                            state_q <= S_MOVE_X;
                        end else if (dist_y != 3'd0) begin
                            y_en_q  <= 1'b1;
                            state_q <= S_MOVE_Y;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                    S_MOVE_X: begin
                        if (x_cell_done) begin
                            if (x_dir_q) cur_x_q <= (cur_x_q == CELL_MAX) ? cur_x_q : cur_x_q + 2'd1;
                            else         cur_x_q <= (cur_x_q == 2'd0) ? cur_x_q : cur_x_q - 2'd1;
                            cells_x_q <= cells_x_q - 3'd1;
                            if (cells_x_q == 3'd1) begin
                                settle_q <= '0;
                                state_q  <= S_SETTLE_X;
                            end
                        end
                    end
                    S_SETTLE_X: begin
                        if (settle_end) begin
                            settle_q <= '0;
                            if (cells_y_q != 3'd0) begin
                                x_en_q  <= 1'b0;
                                y_en_q  <= 1'b1;
                                state_q <= S_MOVE_Y;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            settle_q <= settle_q + SW'(1);
                        end
                    end
                    S_MOVE_Y: begin
                        if (y_cell_done) begin
                            if (y_dir_q) cur_y_q <= (cur_y_q == CELL_MAX) ? cur_y_q : cur_y_q + 2'd1;
                            else         cur_y_q <= (cur_y_q == 2'd0) ? cur_y_q : cur_y_q - 2'd1;
                            cells_y_q <= cells_y_q - 3'd1;
                            if (cells_y_q == 3'd1) begin
                                settle_q <= '0;
                                state_q  <= S_SETTLE_Y;
                            end
                        end
                    end
                    S_SETTLE_Y: begin
                        if (settle_end) begin
                            settle_q <= '0;
                            state_q  <= S_DONE;
                        end else begin
                            settle_q <= settle_q + SW'(1);
                        end
                    end
                    S_DONE: begin
                        arrived_q <= 1'b1;
                        busy_q    <= 1'b0;
                        x_en_q    <= 1'b0;
                        y_en_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign x_dir       = x_dir_q;
    assign y_dir       = y_dir_q;
    assign x_en        = x_en_q;
    assign y_en        = y_en_q;
    assign cur_x       = cur_x_q;
    assign cur_y       = cur_y_q;
    assign busy        = busy_q;
    assign arrived     = arrived_q;
    assign cmd_dropped = cmd_dropped_q;
    assign pos_lost    = pos_lost_q;

endmodule

// File: tb/tb_parking_coord_sequencer.sv
// Bench for parking_coord_sequencer: directed and random moves checked against
// a cell-level model of position, pulse counts and arrival latency.
module tb_parking_coord_sequencer;

    localparam int SPC  = 4;
    localparam int HP   = 2;
    localparam int SC   = 3;
    localparam int CELL = 2 * HP * SPC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coord_cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] target_x = 2'd0;
    logic [1:0] target_y = 2'd0;
    logic       x_step, x_dir, x_en, y_step, y_dir, y_en;
    logic [1:0] cur_x, cur_y;
    logic       busy, arrived, cmd_dropped, pos_lost;

    parking_coord_sequencer #(.STEPS_PER_CELL(SPC), .STEP_HALF_PERIOD(HP), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .coord_cmd_valid(coord_cmd_valid),
        .target_x(target_x), .target_y(target_y), .abort(abort),
        .x_step(x_step), .x_dir(x_dir), .x_en(x_en),
        .y_step(y_step), .y_dir(y_dir), .y_en(y_en),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .arrived(arrived),
        .cmd_dropped(cmd_dropped), .pos_lost(pos_lost)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cx = 0;
    int cy = 0;
    int xr = 0, yr = 0, arr_n = 0, drop_n = 0;
    logic px = 1'b0, py = 1'b0;

    always @(negedge clk) begin
        px <= x_step;
        py <= y_step;
        if (x_step && !px) xr <= xr + 1;
        if (y_step && !py) yr <= yr + 1;
        if (arrived)       arr_n <= arr_n + 1;
        if (cmd_dropped)   drop_n <= drop_n + 1;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({x_step, x_dir, x_en} !== 3'b000) begin
            bad++; $display("FAIL reset_x: got %b want 000", {x_step, x_dir, x_en});
        end
        total++;
        if ({y_step, y_dir, y_en} !== 3'b000) begin
            bad++; $display("FAIL reset_y: got %b want 000", {y_step, y_dir, y_en});
        end
        total++;
        if ({cur_x, cur_y} !== 4'b0000) begin
            bad++; $display("FAIL reset_pos: got %0d,%0d want 0,0", cur_x, cur_y);
        end
        total++;
        if ({busy, arrived, cmd_dropped, pos_lost} !== 4'b0000) begin
            bad++; $display("FAIL reset_status: got %b want 0000", {busy, arrived, cmd_dropped, pos_lost});
        end
        rst = 1'b0;
        cx = 0;
        cy = 0;
    endtask

    // Issue one command and follow it to arrival. inj_at >= 0 fires a second
    // command (3,0) that many cycles after acceptance; it must be dropped.
    task automatic test_move(input int tx, input int ty, input bit with_abort, input int inj_at);
        int dx, dy, sx, sy, lat, y0, i, trk, ex, ey, xr0, yr0, arr0, drop0;
        bit found;
        dx = (tx > cx) ? tx - cx : cx - tx;
        dy = (ty > cy) ? ty - cy : cy - ty;
        sx = (tx > cx) ? 1 : -1;
        sy = (ty > cy) ? 1 : -1;
        lat = 2 + ((dx != 0) ? CELL * dx + SC : 0) + ((dy != 0) ? CELL * dy + SC : 0);
        y0 = (dx != 0) ? 1 + CELL * dx + SC : 1;
        trk = 0;
        found = 1'b0;
        xr0 = xr; yr0 = yr; arr0 = arr_n; drop0 = drop_n;
        @(negedge clk);
        target_x = 2'(tx);
        target_y = 2'(ty);
        coord_cmd_valid = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        coord_cmd_valid = 1'b0;
        abort = 1'b0;
        for (i = 0; i < lat + 20; i++) begin
            @(negedge clk);
            if (i == inj_at) begin
                target_x = 2'd3; target_y = 2'd0; coord_cmd_valid = 1'b1;
            end else begin
                coord_cmd_valid = 1'b0;
            end
            ex = cx + sx * ((i >= 1) ? (((i - 1) / CELL < dx) ? (i - 1) / CELL : dx) : 0);
            ey = cy + sy * ((dy != 0 && i >= y0) ? (((i - y0) / CELL < dy) ? (i - y0) / CELL : dy) : 0);
            if (cur_x !== ex[1:0] || cur_y !== ey[1:0]) trk++;
            if (dx != 0 && i >= 1 && i <= CELL * dx && x_en !== 1'b1) trk++;
            if (dy != 0 && i >= y0 && i < y0 + CELL * dy && y_en !== 1'b1) trk++;
            if (x_step === 1'b1 && x_dir !== (tx > cx)) trk++;
            if (y_step === 1'b1 && y_dir !== (ty > cy)) trk++;
            if (i < lat && busy !== 1'b1) trk++;
            if (arrived === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        coord_cmd_valid = 1'b0;
        total++;
        if (!found || i != lat) begin
            bad++; $display("FAIL latency(%0d,%0d): got %0d found=%0d want %0d", tx, ty, i, found, lat);
        end
        total++;
        if (busy !== 1'b0 || x_en !== 1'b0 || y_en !== 1'b0) begin
            bad++; $display("FAIL end_flags: busy=%b x_en=%b y_en=%b want 000", busy, x_en, y_en);
        end
        total++;
        if (cur_x !== 2'(tx) || cur_y !== 2'(ty)) begin
            bad++; $display("FAIL final_pos: got %0d,%0d want %0d,%0d", cur_x, cur_y, tx, ty);
        end
        total++;
        if (trk != 0) begin
            bad++; $display("FAIL progress(%0d,%0d): %0d cycle errors want 0", tx, ty, trk);
        end
        @(negedge clk);
        #1;
        total++;
        if (xr - xr0 != SPC * dx || yr - yr0 != SPC * dy) begin
            bad++; $display("FAIL pulse_count: got x=%0d y=%0d want x=%0d y=%0d", xr - xr0, yr - yr0, SPC * dx, SPC * dy);
        end
        total++;
        if (arr_n - arr0 != 1 || arrived !== 1'b0) begin
            bad++; $display("FAIL arrived_once: got %0d pulses now=%b want 1 pulse", arr_n - arr0, arrived);
        end
        total++;
        if (drop_n - drop0 != ((inj_at >= 0) ? 1 : 0)) begin
            bad++; $display("FAIL dropped_count: got %0d want %0d", drop_n - drop0, (inj_at >= 0) ? 1 : 0);
        end
        cx = tx;
        cy = ty;
    endtask

    task automatic test_idle_abort();
        int xr0;
        xr0 = xr;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pos_lost !== 1'b0 || xr != xr0) begin
            bad++; $display("FAIL idle_abort: busy=%b pos_lost=%b want 0 0", busy, pos_lost);
        end
        // Command and abort together in IDLE: the command is taken.
        test_move(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b1, -1);
    endtask

    task automatic test_abort();
        int tx, ty, xr0, arr0;
        tx = (cx + 1 + int'($urandom_range(2, 0))) % 4;
        ty = int'($urandom_range(3, 0));
        xr0 = xr;
        arr0 = arr_n;
        @(negedge clk);
        target_x = 2'(tx); target_y = 2'(ty); coord_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        coord_cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        // Two step pulses of the first cell are out.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || x_en !== 1'b0 || x_step !== 1'b0) begin
            bad++; $display("FAIL abort_stop: busy=%b x_en=%b x_step=%b want 000", busy, x_en, x_step);
        end
        total++;
        if (pos_lost !== 1'b1) begin
            bad++; $display("FAIL abort_pos_lost: got %b want 1", pos_lost);
        end
        total++;
        if (cur_x !== 2'(cx) || cur_y !== 2'(cy)) begin
            bad++; $display("FAIL abort_pos: got %0d,%0d want %0d,%0d", cur_x, cur_y, cx, cy);
        end
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (arr_n != arr0 || xr - xr0 != 2 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_quiet: arrived=%0d x_pulses=%0d busy=%b want 0 2 0", arr_n - arr0, xr - xr0, busy);
        end
        test_move(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0, -1);
    endtask

    task automatic test_random(input int n);
        int tx, ty, dx, dy, lat, inj;
        for (int k = 0; k < n; k++) begin
            tx = int'($urandom_range(3, 0));
            ty = int'($urandom_range(3, 0));
            dx = (tx > cx) ? tx - cx : cx - tx;
            dy = (ty > cy) ? ty - cy : cy - ty;
            lat = 2 + ((dx != 0) ? CELL * dx + SC : 0) + ((dy != 0) ? CELL * dy + SC : 0);
            inj = ($urandom_range(1, 0) == 1) ? int'($urandom_range(lat - 2, 0)) : -1;
            test_move(tx, ty, 1'b0, inj);
        end
    endtask

    task automatic test_reset_mid_y();
        int tx, ty, dx, arr0;
        tx = (cx + 1 + int'($urandom_range(2, 0))) % 4;
        ty = (cy + 1 + int'($urandom_range(2, 0))) % 4;
        dx = (tx > cx) ? tx - cx : cx - tx;
        arr0 = arr_n;
        @(negedge clk);
        target_x = 2'(tx); target_y = 2'(ty); coord_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        coord_cmd_valid = 1'b0;
        repeat (1 + CELL * dx + SC + 6) @(negedge clk);
        total++;
        if (y_en !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset_in_y: y_en=%b busy=%b want 1 1", y_en, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({x_step, x_dir, x_en, y_step, y_dir, y_en, cur_x, cur_y, busy, arrived, cmd_dropped, pos_lost} !== 16'h0) begin
            bad++; $display("FAIL reset_mid_y: got %b want all 0",
                {x_step, x_dir, x_en, y_step, y_dir, y_en, cur_x, cur_y, busy, arrived, cmd_dropped, pos_lost});
        end
        cx = 0;
        cy = 0;
        repeat (20) @(negedge clk);
        #1;
        total++;
        if (arr_n != arr0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_quiet: arrived=%0d busy=%b want 0 0", arr_n - arr0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_move(2, 1, 1'b0, -1);
        test_move(0, 3, 1'b0, -1);
        test_move(cx, cy, 1'b0, -1);
        test_move(2, 1, 1'b0, 10);
        test_idle_abort();
        test_abort();
        test_random(6);
        test_reset_mid_y();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_coord_sequencer.md
# parking_coord_sequencer

Converts parsed grid-coordinate commands (target cell 0–3 on X and Y) into step/direction pulse trains for the two gantry stepper drivers of the parking carrier. Sits directly downstream of the Bluetooth command parser: consumes its one-cycle `coord_cmd_valid` strobe with `target_x`/`target_y` and its stop strobe. Tracks the current cell position and moves X fully, settles, then moves Y. Reports busy, arrival and lost-position status.

## Interface
Parameters:
- `STEPS_PER_CELL`, 1600: step pulses per one-cell move. Range 1..65535.
- `STEP_HALF_PERIOD`, 25000: clock cycles that `step` is high and then low (1 kHz at 50 MHz). Must be ≥1.
- `SETTLE_CYCLES`, 500000: dwell in clocks between the X and Y moves, and after the Y move. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `coord_cmd_valid` in 1: one-cycle command strobe.
- `target_x` in 2: target X cell, sampled with the strobe.
- `target_y` in 2: target Y cell, sampled with the strobe.
- `abort` in 1: one-cycle stop strobe, driven from the parser's combined stop command.
- `x_step`, `x_dir`, `x_en` out 1 each: X driver step, direction (1 = increasing cell), enable.
- `y_step`, `y_dir`, `y_en` out 1 each: same for Y.
- `cur_x`, `cur_y` out 2 each: last fully completed cell position.
- `busy` out 1: high from command accept until return to IDLE.
- `arrived` out 1: one-cycle pulse when the target is reached.
- `cmd_dropped` out 1: one-cycle pulse when a command arrives while busy.
- `pos_lost` out 1: sticky flag, set when a move is aborted mid-cell.

## Operation
- States: IDLE, LOAD, MOVE_X, SETTLE_X, MOVE_Y, SETTLE_Y, DONE.
- **IDLE**
  - On `coord_cmd_valid`, latch the targets and go to LOAD.
  - `busy` rises on the same edge.
- **LOAD**
  - Compute `dx = |tx - cur_x|` (3-bit magnitude plus sign) and `dy` likewise.
  - Register `x_dir`/`y_dir`.
  - Next state:
    - `dx != 0` → MOVE_X.
    - `dx == 0`, `dy != 0` → MOVE_Y.
    - Both zero → DONE.
- **MOVE_X**
  - `x_en = 1`.
  - A phase counter toggles `x_step` every `STEP_HALF_PERIOD` cycles, starting low so direction has one half-period of setup.
  - A step counter counts falling edges of `x_step`.
  - At `STEPS_PER_CELL` falling edges: update `cur_x` by ±1, decrement the cell count, reset the step counter.
  - When the cell count reaches 0, go to SETTLE_X.
- **SETTLE_X**
  - `x_en` stays high (holding torque) for `SETTLE_CYCLES`.
  - Then go to MOVE_Y if `dy != 0`, else DONE.
- **MOVE_Y / SETTLE_Y**: mirror MOVE_X / SETTLE_X on the Y axis. SETTLE_Y goes to DONE.
- **DONE**
  - Pulse `arrived` for one cycle.
  - Drop `x_en`/`y_en` and `busy`; return to IDLE.
- **Command while not IDLE**: ignored (targets unchanged); pulse `cmd_dropped`.
- **`abort` in any non-IDLE state**
  - Next state is IDLE; steps, enables and `busy` clear on the next edge; no `arrived`.
  - If a cell was partially stepped (step counter ≠ 0), set `pos_lost`.
  - `cur_x`/`cur_y` keep the last completed cell.
- `abort` in IDLE: no effect.
- `abort` and `coord_cmd_valid` in the same cycle:
  - In IDLE, the command wins.
  - Otherwise the abort wins and `cmd_dropped` pulses.
- **Reset values**: all outputs 0; `cur_x = cur_y = 0`; state IDLE. Reset is the only way to clear `pos_lost`.

## Timing
- Strobe at edge N → LOAD after N. MOVE_X after N+1. First `x_step` rise at N+1+`STEP_HALF_PERIOD`.
- One cell takes `2*STEP_HALF_PERIOD*STEPS_PER_CELL` cycles. `cur_x` updates on the edge producing the last falling step edge of that cell.
- Zero-distance command: `arrived` is high in the cycle after edge N+2; `busy` high for exactly 2 cycles.
- Step counter 16 bits, phase counter ≥ clog2(`STEP_HALF_PERIOD`), settle counter ≥ clog2(`SETTLE_CYCLES`). Cell math is unsigned 2-bit with wrap-free range 0..3.
- Direction outputs change only in LOAD, never while `x_step`/`y_step` is high.

## Structure
- Shared package `parking_pkg`: state enum; `GRID_MAX = 3`; default step/settle constants shared with other motion blocks.
- One sub-module `step_pulse_gen` (enable, half-period counter, per-cell step counter, `cell_done` pulse). Instantiate it once and mux it between axes, or twice.
- The sequencer FSM stays in the top.

## Test plan
Parameters for the bench: `STEPS_PER_CELL = 4`, `STEP_HALF_PERIOD = 2`, `SETTLE_CYCLES = 3`.
- Reset, then command (2,1):
  - 8 `x_step` pulses, `x_dir = 1`, `cur_x` 0→1→2.
  - 3-cycle settle.
  - 4 `y_step` pulses, `cur_y = 1`.
  - `arrived` once; `busy` falls with it.
- From (2,1), command (0,3): `x_dir = 0`, 8 X pulses; `y_dir = 1`, 8 Y pulses; end at `cur = (0,3)`.
- Command equal to the current cell: no step pulses; `arrived` 2 cycles after the strobe.
- Command (3,0) issued while the X move is busy: `cmd_dropped` pulses; original target still reached.
- `abort` after 2 of 4 steps in the first X cell: IDLE next cycle, `x_en = 0`, `pos_lost = 1`, `cur_x` unchanged, no `arrived`. A later command still executes.
- `rst` asserted mid-MOVE_Y: all outputs 0, position (0,0), `pos_lost = 0` the following cycle.
